// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the F/D/E/W pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

   localparam int unsigned WAIT_W_DEF = 5;

   typedef enum logic [1:0] {
      HOLD  = 2'b00,
      ADV   = 2'b01,
      FLUSH = 2'b10
   } upd_t;

   typedef enum logic [1:0] {
      RUN  = 2'b00,
      WAIT = 2'b01,
      HALT = 2'b10
   } pstate_t;

   // Same source/destination match rule the forwarding network uses.
   function automatic logic src_match(input logic       rw_bank,
                                      input logic [4:0] rd,
                                      input logic [5:0] r);
      return (rw_bank == r[5]) && (rd == r[4:0]);
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Decode/execute status in, pipeline register update codes and status out.
interface pipeline_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_W = WAIT_W_DEF,
   parameter int unsigned CNT_W  = 32
);

   logic [5:0]        d_rs;
   logic [5:0]        d_rt;
   logic [1:0]        de_rw;
   logic [4:0]        de_rd;
   logic              de_mem_rd;
   logic [WAIT_W-1:0] de_wait_time;
   logic              de_stop;
   logic              e_redirect;
   logic              resume;

   upd_t              fd_update;
   upd_t              de_update;
   upd_t              ew_update;
   logic              pc_en;
   logic              halted;
   logic              busy;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      output d_rs, d_rt, de_rw, de_rd, de_mem_rd, de_wait_time, de_stop,
             e_redirect, resume,
      input  fd_update, de_update, ew_update, pc_en, halted, busy,
             stall_cnt, flush_cnt
   );

   modport slave (
      input  d_rs, d_rt, de_rw, de_rd, de_mem_rd, de_wait_time, de_stop,
             e_redirect, resume,
      output fd_update, de_update, ew_update, pc_en, halted, busy,
             stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard: a load in E writes a register that D is about to read.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [5:0] d_rs,
   input  logic [5:0] d_rt,
   input  logic [1:0] de_rw,
   input  logic [4:0] de_rd,
   input  logic       de_mem_rd,
   output logic       lu
);

   assign lu = de_mem_rd && (de_rw != 2'b00) &&
               (src_match(de_rw[1], de_rd, d_rs) || src_match(de_rw[1], de_rd, d_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer driving the F/D, D/E, E/W update codes and PC enable.
// Define PIPE_PERF_CNT_EN to build the stall/flush performance counters.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_W = WAIT_W_DEF,
   parameter int unsigned CNT_W  = 32
)
(
   input  logic            clk,
   input  logic            rstn,
   pipeline_ctrl_if.slave  bus
);

   pstate_t           state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   upd_t              fd_c, de_c, ew_c;
   logic              pc_en_c;
   logic              resolve;
   logic              lu;

   hazard_detect u_hazard (
      .d_rs      (bus.d_rs),
      .d_rt      (bus.d_rt),
      .de_rw     (bus.de_rw),
      .de_rd     (bus.de_rd),
      .de_mem_rd (bus.de_mem_rd),
      .lu        (lu)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      fd_c    = HOLD;
      de_c    = HOLD;
      ew_c    = HOLD;
      pc_en_c = 1'b0;
      resolve = 1'b0;
      state_d = state_q;
      cnt_d   = cnt_q;
      if (rstn) begin
         unique case (state_q)
            RUN: begin
               if (bus.de_wait_time != '0) begin
                  ew_c    = FLUSH;
                  cnt_d   = bus.de_wait_time;
                  state_d = WAIT;
               end else begin
                  resolve = 1'b1;
               end
            end
            WAIT: begin
               if (cnt_q > WAIT_W'(1)) begin
                  ew_c  = FLUSH;
                  cnt_d = cnt_q - WAIT_W'(1);
               end else begin
                  // Release cycle: the E instruction's wait_time is already consumed.
                  resolve = 1'b1;
                  cnt_d   = '0;
               end
            end
            HALT: begin
               if (bus.resume) state_d = RUN;
            end
            default: state_d = RUN;
         endcase

         if (resolve) begin
            state_d = RUN;
            if (bus.e_redirect) begin
               fd_c    = FLUSH;
               de_c    = FLUSH;
               ew_c    = ADV;
               pc_en_c = 1'b1;
            end else if (lu) begin
               de_c    = FLUSH;
               ew_c    = ADV;
            end else begin
               fd_c    = ADV;
               de_c    = ADV;
               ew_c    = ADV;
               pc_en_c = 1'b1;
            end
            if (ew_c == ADV && bus.de_stop) state_d = HALT;
         end
      end
   end

   assign bus.fd_update = fd_c;
   assign bus.de_update = de_c;
   assign bus.ew_update = ew_c;
   assign bus.pc_en     = pc_en_c;
   assign bus.halted    = rstn && (state_q == HALT);
   assign bus.busy      = rstn && (state_q == WAIT);

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!pc_en_c && state_q != HALT) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (fd_c == FLUSH)               flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
`else
   assign bus.stall_cnt = {CNT_W{1'b0}};
   assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, directed corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_pipeline_ctrl;

   localparam int unsigned WAIT_W = 5;
   localparam int unsigned CNT_W  = 32;
   localparam logic [1:0] U_HOLD  = 2'b00;
   localparam logic [1:0] U_ADV   = 2'b01;
   localparam logic [1:0] U_FLUSH = 2'b10;

   logic clk = 1'b0;
   logic rstn;

   pipeline_ctrl_if #(.WAIT_W(WAIT_W), .CNT_W(CNT_W)) bus ();

   pipeline_ctrl #(.WAIT_W(WAIT_W), .CNT_W(CNT_W)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference model: E-stage occupancy is tracked as (cycles spent, cycles needed).
   bit          m_halt  = 1'b0;
   int unsigned m_age   = 0;
   int unsigned m_need  = 0;
   int unsigned m_stall = 0;
   int unsigned m_flush = 0;

   typedef struct {
      logic [5:0] rs;
      logic [5:0] rt;
      logic [1:0] rw;
      logic [4:0] rd;
      logic       mem;
      logic       redir;
      logic [1:0] fd;
      logic [1:0] de;
      logic [1:0] ew;
      logic       pc;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [5:0] rs, input logic [5:0] rt, input logic [1:0] rw,
                        input logic [4:0] rd, input logic mem, input logic [4:0] wt,
                        input logic stop, input logic redir, input logic res);
      bus.d_rs         = rs;
      bus.d_rt         = rt;
      bus.de_rw        = rw;
      bus.de_rd        = rd;
      bus.de_mem_rd    = mem;
      bus.de_wait_time = wt;
      bus.de_stop      = stop;
      bus.e_redirect   = redir;
      bus.resume       = res;
   endtask

   task automatic idle();
      drive(6'h00, 6'h00, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Called mid-cycle: compare against the model, advance the model, move to next cycle.
   task automatic check_model(input string tag);
      logic [1:0]  efd, ede, eew;
      logic        epc, ebusy, ehalt, lu_m, stall_m;
      int unsigned need_now;
      logic [31:0] exp_stall, exp_flush;
      efd = U_HOLD; ede = U_HOLD; eew = U_HOLD;
      epc = 1'b0; ebusy = 1'b0; ehalt = 1'b0; stall_m = 1'b0; need_now = 0;
      lu_m = bus.de_mem_rd && (bus.de_rw != 2'b00) &&
             (({bus.de_rw[1], bus.de_rd} == bus.d_rs) || ({bus.de_rw[1], bus.de_rd} == bus.d_rt));
      if (!rstn) begin
         m_halt = 1'b0; m_age = 0; m_need = 0; m_stall = 0; m_flush = 0;
      end else if (m_halt) begin
         ehalt = 1'b1;
      end else begin
         need_now = (m_age == 0) ? 32'(bus.de_wait_time) : m_need;
         ebusy    = (m_age != 0);
         if (m_age < need_now) begin
            eew = U_FLUSH; stall_m = 1'b1;
         end else if (bus.e_redirect) begin
            efd = U_FLUSH; ede = U_FLUSH; eew = U_ADV; epc = 1'b1;
         end else if (lu_m) begin
            ede = U_FLUSH; eew = U_ADV;
         end else begin
            efd = U_ADV; ede = U_ADV; eew = U_ADV; epc = 1'b1;
         end
      end
`ifdef PIPE_PERF_CNT_EN
      exp_stall = m_stall;
      exp_flush = m_flush;
`else
      exp_stall = '0;
      exp_flush = '0;
`endif
      chk({tag, ".fd"},     32'(bus.fd_update), 32'(efd));
      chk({tag, ".de"},     32'(bus.de_update), 32'(ede));
      chk({tag, ".ew"},     32'(bus.ew_update), 32'(eew));
      chk({tag, ".pc_en"},  32'(bus.pc_en),     32'(epc));
      chk({tag, ".busy"},   32'(bus.busy),      32'(ebusy));
      chk({tag, ".halted"}, 32'(bus.halted),    32'(ehalt));
      chk({tag, ".stall"},  bus.stall_cnt,      exp_stall);
      chk({tag, ".flush"},  bus.flush_cnt,      exp_flush);
      if (rstn) begin
         if (!epc && !ehalt) m_stall++;
         if (efd == U_FLUSH) m_flush++;
         if (m_halt) begin
            if (bus.resume) m_halt = 1'b0;
         end else if (stall_m) begin
            m_need = need_now;
            m_age++;
         end else begin
            m_age = 0;
            if (eew == U_ADV && bus.de_stop) m_halt = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input string tag);
      #4;
      check_model(tag);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      idle();
      for (int i = 0; i < 3; i++) tick("reset");
      rstn = 1'b1;
   endtask

   initial begin
      int unsigned busy_seen;
      logic [1:0]  rw;
      logic [4:0]  rd;

      tbl[0] = '{6'h07, 6'h00, 2'b01, 5'd7,  1'b1, 1'b0, U_HOLD,  U_FLUSH, U_ADV, 1'b0};
      tbl[1] = '{6'h27, 6'h00, 2'b01, 5'd7,  1'b1, 1'b0, U_ADV,   U_ADV,   U_ADV, 1'b1};
      tbl[2] = '{6'h27, 6'h00, 2'b10, 5'd7,  1'b1, 1'b0, U_HOLD,  U_FLUSH, U_ADV, 1'b0};
      tbl[3] = '{6'h00, 6'h07, 2'b01, 5'd7,  1'b1, 1'b0, U_HOLD,  U_FLUSH, U_ADV, 1'b0};
      tbl[4] = '{6'h07, 6'h07, 2'b00, 5'd7,  1'b1, 1'b0, U_ADV,   U_ADV,   U_ADV, 1'b1};
      tbl[5] = '{6'h07, 6'h00, 2'b01, 5'd7,  1'b0, 1'b0, U_ADV,   U_ADV,   U_ADV, 1'b1};
      tbl[6] = '{6'h07, 6'h00, 2'b01, 5'd7,  1'b1, 1'b1, U_FLUSH, U_FLUSH, U_ADV, 1'b1};
      tbl[7] = '{6'h11, 6'h12, 2'b01, 5'd7,  1'b1, 1'b1, U_FLUSH, U_FLUSH, U_ADV, 1'b1};
      tbl[8] = '{6'h01, 6'h3f, 2'b11, 5'd31, 1'b1, 1'b0, U_HOLD,  U_FLUSH, U_ADV, 1'b0};
      tbl[9] = '{6'h1f, 6'h00, 2'b11, 5'd31, 1'b1, 1'b0, U_ADV,   U_ADV,   U_ADV, 1'b1};

      rstn = 1'b0;
      idle();
      @(posedge clk);
      #1;

      do_reset();
      tick("post_reset");

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].rs, tbl[i].rt, tbl[i].rw, tbl[i].rd, tbl[i].mem, 5'd0, 1'b0,
               tbl[i].redir, 1'b0);
         #4;
         chk($sformatf("tbl%0d.fd", i),    32'(bus.fd_update), 32'(tbl[i].fd));
         chk($sformatf("tbl%0d.de", i),    32'(bus.de_update), 32'(tbl[i].de));
         chk($sformatf("tbl%0d.ew", i),    32'(bus.ew_update), 32'(tbl[i].ew));
         chk($sformatf("tbl%0d.pc_en", i), 32'(bus.pc_en),     32'(tbl[i].pc));
         check_model($sformatf("tbl%0d", i));
      end

      // Multi-cycle execute, W = 3, with a later wait_time that must be ignored.
      do_reset();
      drive(6'h00, 6'h00, 2'b00, 5'd0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
      tick("w3_start");
      drive(6'h00, 6'h00, 2'b00, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
      busy_seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) idle();
         #4;
         if (bus.busy) busy_seen++;
         check_model($sformatf("w3_%0d", i));
      end
      chk("w3_busy_cycles", busy_seen, 32'd3);

      // W = 1: the single WAIT cycle is already the release cycle.
      drive(6'h00, 6'h00, 2'b00, 5'd0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
      tick("w1_start");
      drive(6'h00, 6'h00, 2'b00, 5'd0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0);
      tick("w1_release");
      idle();
      tick("w1_after");

      // Stop, resume ignored in RUN, resume from HALT.
      drive(6'h00, 6'h00, 2'b00, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      tick("stop");
      idle();
      tick("halted");
      drive(6'h00, 6'h00, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      tick("resume");
      idle();
      tick("after_resume");
      drive(6'h00, 6'h00, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      tick("resume_in_run");

      // Stop combined with a redirect flush still halts.
      drive(6'h07, 6'h00, 2'b01, 5'd7, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
      tick("stop_redir");
      idle();
      tick("stop_redir_halt");
      drive(6'h00, 6'h00, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      tick("stop_redir_resume");
      idle();
      tick("stop_redir_run");

      // Stop in a wait instruction only takes effect on its release cycle.
      drive(6'h00, 6'h00, 2'b00, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
      tick("stopw_0");
      tick("stopw_1");
      tick("stopw_2");
      idle();
      tick("stopw_halt");
      drive(6'h00, 6'h00, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      tick("stopw_resume");

      // Reset mid-WAIT with W = 10, asserted while cnt = 6.
      drive(6'h00, 6'h00, 2'b00, 5'd0, 1'b0, 5'd10, 1'b0, 1'b0, 1'b0);
      tick("rw_start");
      drive(6'h00, 6'h00, 2'b00, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) tick($sformatf("rw_%0d", i));
      rstn = 1'b0;
      #1;
      chk("rw_async.busy", 32'(bus.busy), 32'd0);
      chk("rw_async.ew",   32'(bus.ew_update), 32'(U_HOLD));
      #3;
      check_model("rw_in_reset");
      rstn = 1'b1;
      idle();
      tick("rw_release");
      tick("rw_run");

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rw = 2'($urandom_range(0, 3));
         rd = 5'($urandom_range(0, 3));
         drive(($urandom_range(0, 1) == 0) ? {rw[1], rd} : 6'($urandom),
               ($urandom_range(0, 3) == 0) ? {rw[1], rd} : 6'($urandom_range(0, 3)),
               rw, rd, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 6) == 0) ? 5'($urandom_range(1, 6)) : 5'd0,
               ($urandom_range(0, 11) == 0), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 3) == 0));
         rstn = ($urandom_range(0, 299) != 0);
         tick("rand");
      end
      rstn = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
